// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO and its read-side drain stage.
package fifo_pkg;

    localparam int unsigned MEMORY_WIDTH_DEF = 4;
    localparam int unsigned BUF_DEPTH_DEF    = 2;
    localparam int unsigned STREAM_CNT_W     = 2;

endpackage : fifo_pkg

// File: rtl/fifo_stream_out_if.sv
// FIFO read port plus valid/ready output stream seen by the drain stage.
interface fifo_stream_out_if
    import fifo_pkg::*;
#(
    parameter int unsigned MEMORY_WIDTH = MEMORY_WIDTH_DEF
);

    logic                    fifo_empty;
    logic [MEMORY_WIDTH-1:0] fifo_rdata;
    logic                    fifo_r_en;

    logic                    out_valid;
    logic                    out_ready;
    logic [MEMORY_WIDTH-1:0] out_data;
    logic [STREAM_CNT_W-1:0] out_count;

    // master: the drain stage itself
    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_r_en,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_count
    );

    // slave: FIFO and consumer side
    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_r_en,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_count
    );

endinterface : fifo_stream_out_if

// File: rtl/fifo_stream_buf.sv
// Two-entry register buffer with 1-bit head/tail pointers and occupancy count.
module fifo_stream_buf
    import fifo_pkg::*;
#(
    parameter int unsigned MEMORY_WIDTH = MEMORY_WIDTH_DEF,
    parameter int unsigned CNT_W        = STREAM_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_flush,
    input  logic                    i_wr,
    input  logic [MEMORY_WIDTH-1:0] i_wdata,
    input  logic                    i_rd,
    output logic                    o_valid,
    output logic [MEMORY_WIDTH-1:0] o_data,
    output logic [CNT_W-1:0]        o_count
);

    logic [MEMORY_WIDTH-1:0] r_mem [2];
    logic                    r_head;
    logic                    r_tail;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;

    // A flush wins over any pop issued in the same cycle.
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else begin
            case ({i_wr, i_rd})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (i_flush) begin
                r_head <= 1'b0;
                r_tail <= 1'b0;
            end else begin
                if (i_wr) r_tail <= ~r_tail;
                if (i_rd) r_head <= ~r_head;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    always_comb begin
        o_valid = (r_count != '0);
        o_data  = r_mem[r_head];
        o_count = r_count;
    end

endmodule : fifo_stream_buf

// File: rtl/fifo_stream_out.sv
// FIFO drain stage: issues pops, tracks the 1-cycle read latency, streams words out.
module fifo_stream_out
    import fifo_pkg::*;
#(
    parameter int unsigned MEMORY_WIDTH = MEMORY_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH    = BUF_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    fifo_stream_out_if.master  bus
);

    localparam int unsigned CNT_W = STREAM_CNT_W;

    generate
        if (BUF_DEPTH != 2) begin : g_bad_depth
            $error("fifo_stream_out: BUF_DEPTH must be 2");
        end
    endgenerate

    logic                    r_inflight;
    logic                    w_pop;
    logic                    w_issue;
    logic                    w_capture;
    logic                    w_valid;
    logic [MEMORY_WIDTH-1:0] w_data;
    logic [CNT_W-1:0]        w_count;
    logic [CNT_W:0]          w_pending;

    // Slots still committed after this cycle's pop decide whether another read fits.
    always_comb begin
        w_pop     = w_valid & bus.out_ready;
        w_pending = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}
                  - {{CNT_W{1'b0}}, w_pop};
        w_issue   = !bus.fifo_empty && !flush && (w_pending < (CNT_W+1)'(BUF_DEPTH));
        w_capture = r_inflight & !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    fifo_stream_buf #(
        .MEMORY_WIDTH (MEMORY_WIDTH),
        .CNT_W        (CNT_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_wr    (w_capture),
        .i_wdata (bus.fifo_rdata),
        .i_rd    (w_pop),
        .o_valid (w_valid),
        .o_data  (w_data),
        .o_count (w_count)
    );

    always_comb begin
        bus.fifo_r_en = w_issue;
        bus.out_valid = w_valid;
        bus.out_data  = w_data;
        bus.out_count = w_count;
    end

    a_no_overcommit : assert property (
        @(posedge clk) disable iff (!rst_n)
        (({1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}) <= (CNT_W+1)'(BUF_DEPTH))
    );

    a_no_capture_when_full : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(w_capture && (w_count == CNT_W'(BUF_DEPTH)) && !w_pop)
    );

endmodule : fifo_stream_out

// File: tb/tb_fifo_stream_out.sv
// Directed table-driven bench for fifo_stream_out with a behavioural FIFO read port.
module tb_fifo_stream_out;
    import fifo_pkg::*;

    localparam int unsigned W = 4;

    typedef struct {
        logic        flush;
        logic        ready;
        int unsigned nload;
        logic [15:0] load;
        logic        ren;
        logic        valid;
        logic [3:0]  data;
        logic [1:0]  count;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    fifo_stream_out_if #(.MEMORY_WIDTH(W)) bus ();

    fifo_stream_out #(
        .MEMORY_WIDTH (W),
        .BUF_DEPTH    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo_q [$];
    vec_t         main_vecs [$];
    vec_t         rst_vecs [$];
    int           compared   = 0;
    int           mismatched = 0;

    function automatic vec_t mk(logic fl, logic rd, int unsigned nl, logic [15:0] ld,
                                logic ren, logic vl, logic [3:0] dt, logic [1:0] ct);
        vec_t v;
        v.flush = fl; v.ready = rd; v.nload = nl; v.load = ld;
        v.ren = ren; v.valid = vl; v.data = dt; v.count = ct;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; the FIFO model pops on the edge when r_en was high.
    task automatic tick();
        logic ren;
        ren = bus.fifo_r_en;
        @(posedge clk);
        #1;
        if (ren) begin
            if (fifo_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL pop_from_empty: got r_en=1 expected r_en=0 (t=%0t)", $time);
            end else begin
                bus.fifo_rdata = fifo_q.pop_front();
            end
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag, input int idx);
        logic [15:0] ld;
        string nm;
        flush         = v.flush;
        bus.out_ready = v.ready;
        ld            = v.load;
        for (int unsigned i = 0; i < v.nload; i++) begin
            fifo_q.push_back(ld[4*i +: 4]);
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        #1;
        nm = $sformatf("%s[%0d]", tag, idx);
        check({nm, ".r_en"},  {31'b0, bus.fifo_r_en}, {31'b0, v.ren});
        check({nm, ".valid"}, {31'b0, bus.out_valid}, {31'b0, v.valid});
        check({nm, ".count"}, {30'b0, bus.out_count}, {30'b0, v.count});
        if (v.valid) begin
            check({nm, ".data"}, {28'b0, bus.out_data}, {28'b0, v.data});
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        bus.out_ready  = 1'b0;

        // single word
        main_vecs.push_back(mk(0,1,1,16'h000A, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,1,4'hA,2'd1));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,0,4'h0,2'd0));
        // streaming 1..4
        main_vecs.push_back(mk(0,1,4,16'h4321, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,1,0,16'h0000, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,1,0,16'h0000, 1,1,4'h1,2'd1));
        main_vecs.push_back(mk(0,1,0,16'h0000, 1,1,4'h2,2'd1));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,1,4'h3,2'd1));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,1,4'h4,2'd1));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,0,4'h0,2'd0));
        // back-pressure 5,6,7 with ready low for 5 cycles
        main_vecs.push_back(mk(0,0,3,16'h0765, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,0,0,16'h0000, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,0,0,16'h0000, 0,1,4'h5,2'd1));
        main_vecs.push_back(mk(0,0,0,16'h0000, 0,1,4'h5,2'd2));
        main_vecs.push_back(mk(0,0,0,16'h0000, 0,1,4'h5,2'd2));
        main_vecs.push_back(mk(0,1,0,16'h0000, 1,1,4'h5,2'd2));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,1,4'h6,2'd1));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,1,4'h7,2'd1));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,0,4'h0,2'd0));
        // flush with word 9 in flight, then flush with a full buffer
        main_vecs.push_back(mk(0,0,4,16'hBA98, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,0,0,16'h0000, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(1,0,0,16'h0000, 0,1,4'h8,2'd1));
        main_vecs.push_back(mk(0,0,0,16'h0000, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,0,0,16'h0000, 1,0,4'h0,2'd0));
        main_vecs.push_back(mk(0,0,0,16'h0000, 0,1,4'hA,2'd1));
        main_vecs.push_back(mk(1,1,0,16'h0000, 0,1,4'hA,2'd2));
        main_vecs.push_back(mk(0,1,0,16'h0000, 0,0,4'h0,2'd0));
        // mid-stream reset: preload C,D,E
        rst_vecs.push_back(mk(0,0,3,16'h0EDC, 1,0,4'h0,2'd0));
        rst_vecs.push_back(mk(0,0,0,16'h0000, 1,0,4'h0,2'd0));

        #12;
        check("reset.valid", {31'b0, bus.out_valid}, 32'h0);
        check("reset.count", {30'b0, bus.out_count}, 32'h0);
        check("reset.data",  {28'b0, bus.out_data},  32'h0);
        check("reset.r_en",  {31'b0, bus.fifo_r_en}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < main_vecs.size(); i++) begin
            apply_vec(main_vecs[i], "main", i);
        end

        for (int i = 0; i < rst_vecs.size(); i++) begin
            apply_vec(rst_vecs[i], "pre_rst", i);
        end
        #1;
        check("pre_rst.valid", {31'b0, bus.out_valid}, 32'h1);
        check("pre_rst.data",  {28'b0, bus.out_data},  32'hC);
        #2;
        rst_n = 1'b0;
        fifo_q.delete();
        bus.fifo_empty = 1'b1;
        #1;
        check("async_rst.valid", {31'b0, bus.out_valid}, 32'h0);
        check("async_rst.count", {30'b0, bus.out_count}, 32'h0);
        check("async_rst.data",  {28'b0, bus.out_data},  32'h0);
        check("async_rst.r_en",  {31'b0, bus.fifo_r_en}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rst_vecs.delete();
        rst_vecs.push_back(mk(0,1,2,16'h003F, 1,0,4'h0,2'd0));
        rst_vecs.push_back(mk(0,1,0,16'h0000, 1,0,4'h0,2'd0));
        rst_vecs.push_back(mk(0,1,0,16'h0000, 0,1,4'hF,2'd1));
        rst_vecs.push_back(mk(0,1,0,16'h0000, 0,1,4'h3,2'd1));
        rst_vecs.push_back(mk(0,1,0,16'h0000, 0,0,4'h0,2'd0));
        for (int i = 0; i < rst_vecs.size(); i++) begin
            apply_vec(rst_vecs[i], "post_rst", i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fifo_stream_out
